// File: rtl/rpn_token_sequencer.sv
// rtl/rpn_token_sequencer.sv - RPN token stream to stack-ALU opcode sequencer with result handshake
// Define RPN_OPCOUNT_EN to add the res_ops operator-count port.
module rpn_token_sequencer #(
  parameter int N           = 8,
  parameter int STACK_DEPTH = 8,
  parameter int ALU_LAT     = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tok_valid,
  output logic         tok_ready,
  input  logic         tok_is_op,
  input  logic [N-1:0] tok_data,
  input  logic         tok_last,
  output logic [2:0]   opcode,
  output logic [N-1:0] input_data,
  input  logic [N-1:0] output_data,
  input  logic         overflow,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_data,
  output logic         res_overflow,
  output logic         res_error
`ifdef RPN_OPCOUNT_EN
  ,
  output logic [7:0]   res_ops
`endif
);

  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int LW = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

  localparam logic [DW-1:0] DEPTH_MAX = DW'(STACK_DEPTH);
  localparam logic [LW-1:0] LAT_DONE  = LW'(ALU_LAT);

  localparam logic [2:0] OP_IDLE = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  typedef enum logic [2:0] {
    S_RUN    = 3'd0,
    S_WAIT   = 3'd1,
    S_DRAIN  = 3'd2,
    S_DWAIT  = 3'd3,
    S_RESULT = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   depth_q, depth_d;
  logic [LW-1:0]   lat_q, lat_d;
  logic            last_q, last_d;
  logic            first_q, first_d;
  logic            ov_q, ov_d;
  logic            err_q, err_d;
  logic            ready_q, ready_d;
  logic [2:0]      opcode_q, opcode_d;
  logic [N-1:0]    idata_q, idata_d;
  logic [N-1:0]    rdata_q, rdata_d;
`ifdef RPN_OPCOUNT_EN
  logic [7:0]      ops_q, ops_d;
`endif

  logic tok_hs;
  assign tok_hs = tok_valid && ready_q && (state_q == S_RUN);

  always_comb begin
    state_d  = state_q;
    depth_d  = depth_q;
    lat_d    = lat_q;
    last_d   = last_q;
    first_d  = first_q;
    ov_d     = ov_q;
    err_d    = err_q;
    opcode_d = OP_IDLE;
    idata_d  = idata_q;
    rdata_d  = rdata_q;
`ifdef RPN_OPCOUNT_EN
    ops_d    = ops_q;
`endif

    case (state_q)
      S_RUN: begin
        if (tok_hs) begin
          last_d = tok_last;
          if (!tok_is_op) begin
            if (depth_q == DEPTH_MAX) begin
              err_d = 1'b1;
            end else begin
              opcode_d = OP_PUSH;
              idata_d  = tok_data;
              depth_d  = depth_q + DW'(1);
            end
            if (tok_last) begin
              state_d = S_DRAIN;
              first_d = 1'b1;
            end
          end else if (depth_q < DW'(2)) begin
            err_d = 1'b1;
            if (tok_last) begin
              state_d = S_DRAIN;
              first_d = 1'b1;
            end
          end else begin
            opcode_d = tok_data[0] ? OP_MUL : OP_ADD;
            depth_d  = depth_q - DW'(1);
            lat_d    = '0;
            state_d  = S_WAIT;
`ifdef RPN_OPCOUNT_EN
            ops_d    = (ops_q == 8'hFF) ? ops_q : ops_q + 8'd1;
`endif
          end
        end
      end

      S_WAIT: begin
        if (lat_q == LAT_DONE) begin
          ov_d  = ov_q | overflow;
          lat_d = '0;
          if (last_q) begin
            state_d = S_DRAIN;
            first_d = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end

      // Every remaining entry is popped so the ALU stack starts empty next time.
      S_DRAIN: begin
        if (first_q && (depth_q == '0)) begin
          err_d   = 1'b1;
          rdata_d = '0;
          first_d = 1'b0;
          state_d = S_RESULT;
        end else begin
          if (first_q && (depth_q != DW'(1))) begin
            err_d = 1'b1;
          end
          opcode_d = OP_POP;
          depth_d  = depth_q - DW'(1);
          lat_d    = '0;
          state_d  = S_DWAIT;
        end
      end

      S_DWAIT: begin
        if (lat_q == LAT_DONE) begin
          if (first_q) begin
            rdata_d = output_data;
          end
          first_d = 1'b0;
          lat_d   = '0;
          state_d = (depth_q == '0) ? S_RESULT : S_DRAIN;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end

      S_RESULT: begin
        if (res_ready) begin
          ov_d    = 1'b0;
          err_d   = 1'b0;
          last_d  = 1'b0;
          state_d = S_RUN;
`ifdef RPN_OPCOUNT_EN
          ops_d   = 8'd0;
`endif
        end
      end

      default: begin
        state_d = S_RUN;
      end
    endcase

    ready_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_RUN;
      depth_q  <= '0;
      lat_q    <= '0;
      last_q   <= 1'b0;
      first_q  <= 1'b0;
      ov_q     <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
      opcode_q <= OP_IDLE;
      idata_q  <= '0;
      rdata_q  <= '0;
`ifdef RPN_OPCOUNT_EN
      ops_q    <= 8'd0;
`endif
    end else begin
      state_q  <= state_d;
      depth_q  <= depth_d;
      lat_q    <= lat_d;
      last_q   <= last_d;
      first_q  <= first_d;
      ov_q     <= ov_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
      opcode_q <= opcode_d;
      idata_q  <= idata_d;
      rdata_q  <= rdata_d;
`ifdef RPN_OPCOUNT_EN
      ops_q    <= ops_d;
`endif
    end
  end

  assign tok_ready    = ready_q;
  assign opcode       = opcode_q;
  assign input_data   = idata_q;
  assign res_valid    = (state_q == S_RESULT);
  assign res_data     = rdata_q;
  assign res_overflow = ov_q;
  assign res_error    = err_q;
`ifdef RPN_OPCOUNT_EN
  assign res_ops      = ops_q;
`endif

endmodule
